regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Controller in front of the 32x32 register file's single write port. Shares that port between two write-back requesters, e.g. requester 0 = ALU/load path and requester 1 = multi-cycle mul/div unit.
- Keeps a busy scoreboard of destination registers allocated at dispatch and not yet written back.
- Reports read-after-write hazards for the two register-file read addresses.

Parameters:
- DATA_W, 32, write-data width
- ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  dispatch requests that alloc_reg be marked busy
- alloc_reg  in  ADDR_W  destination register being allocated
- alloc_ready  out  1  allocation accepted this cycle
- wb0_valid / wb1_valid  in  1  requester has a write pending
- wb0_reg / wb1_reg  in  ADDR_W  write destination
- wb0_data / wb1_data  in  DATA_W  write data
- wb0_ready / wb1_ready  out  1  write accepted this cycle (grant)
- rf_write_enable  out  1  register-file write enable
- rf_write_reg  out  ADDR_W  register-file write address
- rf_write_data  out  DATA_W  register-file write data
- read_reg1 / read_reg2  in  ADDR_W  current register-file read addresses
- hazard1 / hazard2  out  1  addressed register has an outstanding write
- fwd1_valid / fwd2_valid  out  1  bypass data valid (optional feature)
- fwd1_data / fwd2_data  out  DATA_W  bypass data (optional feature)
- busy_vec  out  2**ADDR_W  scoreboard snapshot, bit k = register k busy

Behaviour:
- Reset: busy_vec=0, rr_ptr=0, rf_write_enable=0, rf_write_reg=0, rf_write_data=0. alloc_ready, wb*_ready, hazard* and fwd* are all 0 while reset is high.
- Handshakes are combinational valid/ready. A transfer occurs at the edge where valid&ready=1. A requester must hold reg and data stable until ready.
- Arbitration is 2-way round-robin with pointer rr_ptr.
  - Only one valid: it is granted.
  - Both valid: requester rr_ptr is granted.
  - After any grant, rr_ptr = the non-granted index.
  - No grant: rr_ptr holds.
  - Neither requester is ever starved.
- Write stage is one registered stage. On a grant at edge E, the rf_write_* outputs carry that write during cycle E..E+1, and the register file captures it at edge E+1.
  - With no grant at edge E, rf_write_enable=0 in the following cycle.
  - Throughput is one write per cycle.
- Register 0: the transfer still completes (ready=1) but the registered rf_write_enable=0. Busy bit 0 is never set.
- Scoreboard set: on alloc transfer, busy[alloc_reg]=1 at that edge.
- Scoreboard clear: busy[rf_write_reg]=0 at the edge where rf_write_enable=1, i.e. when the data lands.
- alloc_ready = !reset && (alloc_reg==0 || !busy[alloc_reg]). At most one outstanding write per register.
- Same edge, clear of register r and alloc of r: alloc_ready is 0 that cycle (busy still 1), so busy[r]=0 after the edge and the alloc retries next cycle.
- A write-back to a non-busy register is legal: it is written, and busy is unaffected.
- hazardN = busy[read_regN] && read_regN!=0. This is combinational from the current scoreboard.
- Reset asserted mid-operation: a pending registered write is dropped (rf_write_enable=0 next cycle) and every busy bit is cleared.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - When rf_write_enable=1 and rf_write_reg==read_regN!=0: fwdN_valid=1, fwdN_data=rf_write_data, and hazardN=0 that cycle.
  - Otherwise fwdN_valid=0, fwdN_data=0, and hazardN is as above.
- Undefined: fwdN_valid=0 and fwdN_data=0 permanently; hazardN is unaffected by the write stage.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0
  - grant index type (0/1)
  - busy-vector type
- Sub-module rr_arb_2 (2-way round-robin arbiter with pointer register) instantiated once.
- Scoreboard and write stage stay in the top module.

Test Plan:
- Reset, then alloc r5, then wb0 write r5=0xDEADBEEF: busy_vec[5]=1 after alloc; rf_write_enable=1, reg=5, data=0xDEADBEEF one cycle after grant; busy_vec[5]=0 the edge after; hazard1 with read_reg1=5 goes 1 then 0.
- wb0 (r3=0x11) and wb1 (r4=0x22) both valid for 4 cycles from reset: grant order wb0, wb1, wb0, wb1; rf_write_reg sequence 3, 4, 3, 4.
- Write-back to r0 with data 0xFFFFFFFF: wb0_ready=1, rf_write_enable stays 0; alloc r0 leaves busy_vec=0 and hazard1 with read_reg1=0 is 0.
- Alloc r7, then alloc r7 again before write-back: second alloc_ready=0 until the cycle after r7's write lands, then 1.
- Alloc r9, grant wb1 r9=0xA5A5A5A5, assert reset the same cycle as rf_write_enable=1: next cycle rf_write_enable=0 and busy_vec=0.
- With REGFILE_WB_BYPASS_EN: read_reg2=12 while rf_write_reg=12, data=0x1234 → fwd2_valid=1, fwd2_data=0x1234, hazard2=0. Without the macro the same stimulus → fwd2_valid=0, hazard2=1.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
// Consumed by regfile_wb_scheduler (build option: REGFILE_WB_BYPASS_EN) and rr_arb_2.
package regfile_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        GRANT_WB0 = 1'b0,
        GRANT_WB1 = 1'b1
    } grant_idx_e;

    typedef logic [NUM_REGS-1:0] busy_vec_t;

    function automatic grant_idx_e other_idx(input grant_idx_e idx);
        return (idx == GRANT_WB0) ? GRANT_WB1 : GRANT_WB0;
    endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and always moves to the loser after a grant so neither side can starve.
module rr_arb_2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output grant_idx_e gnt_idx_o
);

    grant_idx_e ptr_q, ptr_d;

    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = GRANT_WB0;
        ptr_d     = ptr_q;
        if (!reset && (req_i != 2'b00)) begin
            if (req_i == 2'b11) begin
                gnt_idx_o = ptr_q;
            end else if (req_i[1]) begin
                gnt_idx_o = GRANT_WB1;
            end else begin
                gnt_idx_o = GRANT_WB0;
            end
            if (gnt_idx_o == GRANT_WB1) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
            ptr_d = other_idx(gnt_idx_o);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= GRANT_WB0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port controller: arbitrates two write-back sources, tracks busy destinations,
// reports RAW hazards. Define REGFILE_WB_BYPASS_EN to forward the in-flight write.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic [ADDR_W-1:0]    alloc_reg,
    output logic                 alloc_ready,
    input  logic                 wb0_valid,
    input  logic [ADDR_W-1:0]    wb0_reg,
    input  logic [DATA_W-1:0]    wb0_data,
    output logic                 wb0_ready,
    input  logic                 wb1_valid,
    input  logic [ADDR_W-1:0]    wb1_reg,
    input  logic [DATA_W-1:0]    wb1_data,
    output logic                 wb1_ready,
    output logic                 rf_write_enable,
    output logic [ADDR_W-1:0]    rf_write_reg,
    output logic [DATA_W-1:0]    rf_write_data,
    input  logic [ADDR_W-1:0]    read_reg1,
    input  logic [ADDR_W-1:0]    read_reg2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic                 fwd1_valid,
    output logic                 fwd2_valid,
    output logic [DATA_W-1:0]    fwd1_data,
    output logic [DATA_W-1:0]    fwd2_data,
    output logic [2**ADDR_W-1:0] busy_vec
);
    import regfile_ctrl_pkg::*;

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [1:0]        wb_req, wb_gnt;
    grant_idx_e        gnt_idx;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              alloc_fire;
    logic              fwd1_hit, fwd2_hit;

    assign wb_req = {wb1_valid, wb0_valid};

    rr_arb_2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (wb_req),
        .gnt_o     (wb_gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign wb0_ready = wb_gnt[0];
    assign wb1_ready = wb_gnt[1];
    assign gnt_any   = |wb_gnt;

    always_comb begin
        sel_reg  = wb0_reg;
        sel_data = wb0_data;
        if (gnt_idx == GRANT_WB1) begin
            sel_reg  = wb1_reg;
            sel_data = wb1_data;
        end
    end

    // A granted write to r0 still completes the handshake but never reaches the file.
    always_comb begin
        wr_en_d   = gnt_any && (sel_reg != ZERO_REG);
        wr_reg_d  = gnt_any ? sel_reg  : wr_reg_q;
        wr_data_d = gnt_any ? sel_data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_write_enable = wr_en_q;
    assign rf_write_reg    = wr_reg_q;
    assign rf_write_data   = wr_data_q;

    assign alloc_ready = !reset && ((alloc_reg == ZERO_REG) || !busy_q[alloc_reg]);
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Clear on data landing first so a fresh allocation of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_reg_q] = 1'b0;
        end
        if (alloc_fire && (alloc_reg != ZERO_REG)) begin
            busy_d[alloc_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd1_hit   = !reset && wr_en_q && (wr_reg_q == read_reg1) && (read_reg1 != ZERO_REG);
    assign fwd2_hit   = !reset && wr_en_q && (wr_reg_q == read_reg2) && (read_reg2 != ZERO_REG);
    assign fwd1_valid = fwd1_hit;
    assign fwd2_valid = fwd2_hit;
    assign fwd1_data  = fwd1_hit ? wr_data_q : '0;
    assign fwd2_data  = fwd2_hit ? wr_data_q : '0;
`else
    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

    // A forwarded read is not a stall, so the bypass hit masks the hazard.
    assign hazard1 = !reset && busy_q[read_reg1] && (read_reg1 != ZERO_REG) && !fwd1_hit;
    assign hazard2 = !reset && busy_q[read_reg2] && (read_reg2 != ZERO_REG) && !fwd2_hit;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler; expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic        alloc_ready;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_reg, wb1_reg;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [4:0]  read_reg1, read_reg2;
    logic        hazard1, hazard2;
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
    logic [31:0] busy_vec;

    int checks;
    int failures;

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_reg       (alloc_reg),
        .alloc_ready     (alloc_ready),
        .wb0_valid       (wb0_valid),
        .wb0_reg         (wb0_reg),
        .wb0_data        (wb0_data),
        .wb0_ready       (wb0_ready),
        .wb1_valid       (wb1_valid),
        .wb1_reg         (wb1_reg),
        .wb1_data        (wb1_data),
        .wb1_ready       (wb1_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data),
        .read_reg1       (read_reg1),
        .read_reg2       (read_reg2),
        .hazard1         (hazard1),
        .hazard2         (hazard2),
        .fwd1_valid      (fwd1_valid),
        .fwd2_valid      (fwd2_valid),
        .fwd1_data       (fwd1_data),
        .fwd2_data       (fwd2_data),
        .busy_vec        (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_inputs;
        alloc_valid = 1'b0;
        alloc_reg   = '0;
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
        wb0_reg     = '0;
        wb1_reg     = '0;
        wb0_data    = '0;
        wb1_data    = '0;
        read_reg1   = '0;
        read_reg2   = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        apply_reset();
        reset = 1'b1;
        alloc_valid = 1'b1;
        alloc_reg = 5'd3;
        wb0_valid = 1'b1;
        wb0_reg = 5'd3;
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_alloc_ready got=%b exp=0", alloc_ready); end
        checks++;
        if (wb0_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb0_ready got=%b exp=0", wb0_ready); end
        checks++;
        if (busy_vec !== 32'h0) begin failures++; $display("[TB] FAIL reset_busy got=%h exp=0", busy_vec); end
        checks++;
        if ({rf_write_enable, rf_write_reg, rf_write_data} !== 38'h0) begin
            failures++;
            $display("[TB] FAIL reset_write_stage got en=%b reg=%0d data=%h exp all 0", rf_write_enable, rf_write_reg, rf_write_data);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_alloc_wb;
        alloc_valid = 1'b1;
        alloc_reg   = 5'd5;
        read_reg1   = 5'd5;
        #1;
        checks++;
        if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL alloc5_ready got=%b exp=1", alloc_ready); end
        checks++;
        if (hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL alloc5_hazard_before got=%b exp=0", hazard1); end
        @(negedge clk);
        alloc_valid = 1'b0;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd5;
        wb0_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0020) begin failures++; $display("[TB] FAIL alloc5_busy got=%h exp=00000020", busy_vec); end
        checks++;
        if (hazard1 !== 1'b1) begin failures++; $display("[TB] FAIL alloc5_hazard got=%b exp=1", hazard1); end
        checks++;
        if (wb0_ready !== 1'b1) begin failures++; $display("[TB] FAIL wb0_r5_ready got=%b exp=1", wb0_ready); end
        @(negedge clk);
        wb0_valid = 1'b0;
        #1;
        checks++;
        if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL wb_r5_write got en=%b reg=%0d data=%h exp en=1 reg=5 data=deadbeef", rf_write_enable, rf_write_reg, rf_write_data);
        end
        checks++;
        if (busy_vec !== 32'h0000_0020) begin failures++; $display("[TB] FAIL wb_r5_busy_inflight got=%h exp=00000020", busy_vec); end
`ifdef REGFILE_WB_BYPASS_EN
        checks++;
        if ({hazard1, fwd1_valid, fwd1_data} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL wb_r5_fwd1 got haz=%b fv=%b fd=%h exp haz=0 fv=1 fd=deadbeef", hazard1, fwd1_valid, fwd1_data);
        end
`else
        checks++;
        if ({hazard1, fwd1_valid, fwd1_data} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL wb_r5_fwd1 got haz=%b fv=%b fd=%h exp haz=1 fv=0 fd=0", hazard1, fwd1_valid, fwd1_data);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin failures++; $display("[TB] FAIL wb_r5_busy_cleared got=%h exp=0", busy_vec); end
        checks++;
        if (hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL wb_r5_hazard_cleared got=%b exp=0", hazard1); end
        checks++;
        if (rf_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL wb_r5_idle_en got=%b exp=0", rf_write_enable); end
        idle_inputs();
    endtask

    task automatic test_round_robin;
        logic [4:0]  exp_reg [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [31:0] exp_data[4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        wb0_valid = 1'b1;
        wb0_reg   = 5'd3;
        wb0_data  = 32'h11;
        wb1_valid = 1'b1;
        wb1_reg   = 5'd4;
        wb1_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({wb1_ready, wb0_ready} !== exp_gnt[i]) begin
                failures++;
                $display("[TB] FAIL rr_grant_%0d got=%b exp=%b", i, {wb1_ready, wb0_ready}, exp_gnt[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, exp_reg[i], exp_data[i]}) begin
                failures++;
                $display("[TB] FAIL rr_write_%0d got en=%b reg=%0d data=%h exp en=1 reg=%0d data=%h",
                         i, rf_write_enable, rf_write_reg, rf_write_data, exp_reg[i], exp_data[i]);
            end
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0) begin failures++; $display("[TB] FAIL rr_busy_untouched got=%h exp=0", busy_vec); end
    endtask

    task automatic test_reg_zero;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd0;
        wb0_data  = 32'hFFFFFFFF;
        #1;
        checks++;
        if (wb0_ready !== 1'b1) begin failures++; $display("[TB] FAIL r0_wb_ready got=%b exp=1", wb0_ready); end
        @(negedge clk);
        wb0_valid   = 1'b0;
        alloc_valid = 1'b1;
        alloc_reg   = 5'd0;
        read_reg1   = 5'd0;
        #1;
        checks++;
        if (rf_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL r0_wb_en got=%b exp=0", rf_write_enable); end
        checks++;
        if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL r0_alloc_ready got=%b exp=1", alloc_ready); end
        @(negedge clk);
        alloc_valid = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin failures++; $display("[TB] FAIL r0_alloc_busy got=%h exp=0", busy_vec); end
        checks++;
        if (hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL r0_hazard got=%b exp=0", hazard1); end
        idle_inputs();
    endtask

    task automatic test_alloc_conflict;
        alloc_valid = 1'b1;
        alloc_reg   = 5'd7;
        #1;
        checks++;
        if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL r7_first_alloc got=%b exp=1", alloc_ready); end
        @(negedge clk);
        wb1_valid = 1'b1;
        wb1_reg   = 5'd7;
        wb1_data  = 32'h77;
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL r7_second_alloc_busy got=%b exp=0", alloc_ready); end
        checks++;
        if (wb1_ready !== 1'b1) begin failures++; $display("[TB] FAIL r7_wb1_ready got=%b exp=1", wb1_ready); end
        @(negedge clk);
        wb1_valid = 1'b0;
        #1;
        checks++;
        if ({rf_write_enable, alloc_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL r7_landing got en=%b alloc_ready=%b exp en=1 alloc_ready=0", rf_write_enable, alloc_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL r7_alloc_after_land got=%b exp=1", alloc_ready); end
        @(negedge clk);
        alloc_valid = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0080) begin failures++; $display("[TB] FAIL r7_realloc_busy got=%h exp=00000080", busy_vec); end
        idle_inputs();
    endtask

    task automatic test_reset_midflight;
        apply_reset();
        alloc_valid = 1'b1;
        alloc_reg   = 5'd2;
        @(negedge clk);
        alloc_reg   = 5'd9;
        @(negedge clk);
        alloc_valid = 1'b0;
        wb1_valid = 1'b1;
        wb1_reg   = 5'd9;
        wb1_data  = 32'hA5A5A5A5;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0204) begin failures++; $display("[TB] FAIL mid_busy_before got=%h exp=00000204", busy_vec); end
        @(negedge clk);
        wb1_valid = 1'b0;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd6;
        wb0_data  = 32'h66;
        reset     = 1'b1;
        #1;
        checks++;
        if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd9, 32'hA5A5A5A5}) begin
            failures++;
            $display("[TB] FAIL mid_write_stage got en=%b reg=%0d data=%h exp en=1 reg=9 data=a5a5a5a5", rf_write_enable, rf_write_reg, rf_write_data);
        end
        checks++;
        if (wb0_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_wb0_ready_in_reset got=%b exp=0", wb0_ready); end
        @(negedge clk);
        reset = 1'b0;
        wb0_valid = 1'b0;
        #1;
        checks++;
        if (rf_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL mid_write_dropped got=%b exp=0", rf_write_enable); end
        checks++;
        if (busy_vec !== 32'h0) begin failures++; $display("[TB] FAIL mid_busy_cleared got=%h exp=0", busy_vec); end
        idle_inputs();
    endtask

    task automatic test_bypass;
        alloc_valid = 1'b1;
        alloc_reg   = 5'd12;
        @(negedge clk);
        alloc_valid = 1'b0;
        read_reg2 = 5'd12;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd12;
        wb0_data  = 32'h1234;
        @(negedge clk);
        wb0_valid = 1'b0;
        #1;
        checks++;
        if (rf_write_reg !== 5'd12) begin failures++; $display("[TB] FAIL byp_write_reg got=%0d exp=12", rf_write_reg); end
`ifdef REGFILE_WB_BYPASS_EN
        checks++;
        if ({fwd2_valid, fwd2_data, hazard2} !== {1'b1, 32'h1234, 1'b0}) begin
            failures++;
            $display("[TB] FAIL byp_fwd2 got fv=%b fd=%h haz=%b exp fv=1 fd=00001234 haz=0", fwd2_valid, fwd2_data, hazard2);
        end
`else
        checks++;
        if ({fwd2_valid, fwd2_data, hazard2} !== {1'b0, 32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL byp_fwd2 got fv=%b fd=%h haz=%b exp fv=0 fd=0 haz=1", fwd2_valid, fwd2_data, hazard2);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if ({fwd2_valid, hazard2} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL byp_after_land got fv=%b haz=%b exp fv=0 haz=0", fwd2_valid, hazard2);
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_alloc_wb();
        test_round_robin();
        test_reg_zero();
        test_alloc_conflict();
        test_reset_midflight();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
